// File: rtl/plate_ctrl.sv
// Paddle controller: keeps the plate as a run of set bits in a row bitmap,
// moves it on game ticks with hold-to-accelerate, and applies buffered resizes.
module plate_ctrl #(
  parameter int FIELD_W      = 16,
  parameter int PLATE_W_INIT = 4,
  parameter int PLATE_W_MIN  = 2,
  parameter int PLATE_W_MAX  = 8,
  parameter int ACCEL_TICKS  = 4,
  parameter int MAX_STEP     = 3,
  localparam int POS_W       = $clog2(FIELD_W)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               tick,
  input  logic [3:0]         control,
  input  logic               grow,
  input  logic               shrink,
  output logic [FIELD_W-1:0] data_out,
  output logic [POS_W-1:0]   plate_pos,
  output logic [POS_W:0]     plate_width,
  output logic               at_low_edge,
  output logic               at_high_edge,
  output logic               boost
);

  localparam int CNT_W = $clog2(ACCEL_TICKS + 1);
  localparam logic [POS_W:0]   FW_L    = (POS_W+1)'(FIELD_W);
  localparam logic [POS_W:0]   MIN_L   = (POS_W+1)'(PLATE_W_MIN);
  localparam logic [POS_W:0]   MAX_L   = (POS_W+1)'(PLATE_W_MAX);
  localparam logic [POS_W:0]   INIT_L  = (POS_W+1)'(PLATE_W_INIT);
  localparam logic [POS_W:0]   STEP_L  = (POS_W+1)'(MAX_STEP);
  localparam logic [POS_W-1:0] RPOS_L  = POS_W'((FIELD_W - PLATE_W_INIT) / 2);
  localparam logic [CNT_W-1:0] ACC_L   = CNT_W'(ACCEL_TICKS);
  localparam logic [FIELD_W:0] RONES_L = ({{FIELD_W{1'b0}}, 1'b1} << PLATE_W_INIT) - (FIELD_W+1)'(1);
  localparam logic [FIELD_W-1:0] RMAP_L = RONES_L[FIELD_W-1:0] << RPOS_L;

  typedef enum logic [1:0] {DIR_NONE, DIR_LOW, DIR_HIGH} dir_e;

  logic [POS_W-1:0]   pos_q, pos_d;
  logic [POS_W:0]     width_q, width_d;
  logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
  dir_e               last_dir_q, last_dir_d;
  logic               pend_grow_q, pend_grow_d, pend_shrink_q, pend_shrink_d;
  logic [FIELD_W-1:0] data_out_q, data_out_d;
  logic               low_q, low_d, high_q, high_d, boost_q, boost_d;

  dir_e               dir;
  logic [POS_W:0]     base, step, pos_ext, lim;
  logic               want_grow, want_shrink;
  logic [FIELD_W:0]   ones;

  always_comb begin
    pos_d         = pos_q;
    width_d       = width_q;
    hold_cnt_d    = hold_cnt_q;
    last_dir_d    = last_dir_q;
    pend_grow_d   = pend_grow_q | grow;
    pend_shrink_d = pend_shrink_q | shrink;
    want_grow     = pend_grow_q | grow;
    want_shrink   = pend_shrink_q | shrink;
    pos_ext       = {1'b0, pos_q};
    lim           = FW_L - width_q;
    dir           = DIR_NONE;
    base          = '0;
    case (control)
      4'b0001: begin dir = DIR_LOW;  base = (POS_W+1)'(1); end
      4'b0011: begin dir = DIR_LOW;  base = (POS_W+1)'(2); end
      4'b0100: begin dir = DIR_HIGH; base = (POS_W+1)'(1); end
      4'b0110: begin dir = DIR_HIGH; base = (POS_W+1)'(2); end
      default: begin dir = DIR_NONE; base = '0; end
    endcase
    step = base + {{POS_W{1'b0}}, boost_q};
    if (step > STEP_L) step = STEP_L;

    if (tick) begin
      pend_grow_d   = 1'b0;
      pend_shrink_d = 1'b0;
      if (want_grow ^ want_shrink) begin
        // resize tick: no movement, acceleration restarts
        hold_cnt_d = '0;
        last_dir_d = DIR_NONE;
        if (want_grow && width_q != MAX_L) begin
          width_d = width_q + (POS_W+1)'(1);
          if (pos_ext + width_q >= FW_L) pos_d = pos_q - POS_W'(1);
        end else if (want_shrink && width_q != MIN_L) begin
          width_d = width_q - (POS_W+1)'(1);
        end
      end else begin
        case (dir)
          DIR_LOW:  pos_d = (pos_ext < step) ? '0 : POS_W'(pos_ext - step);
          DIR_HIGH: pos_d = (pos_ext + step > lim) ? POS_W'(lim) : POS_W'(pos_ext + step);
          default:  pos_d = pos_q;
        endcase
        if (dir != DIR_NONE && dir == last_dir_q)
          hold_cnt_d = (hold_cnt_q == ACC_L) ? hold_cnt_q : hold_cnt_q + CNT_W'(1);
        else
          hold_cnt_d = (dir != DIR_NONE) ? CNT_W'(1) : '0;
        last_dir_d = dir;
      end
    end

    ones       = ({{FIELD_W{1'b0}}, 1'b1} << width_d) - (FIELD_W+1)'(1);
    data_out_d = ones[FIELD_W-1:0] << pos_d;
    low_d      = (pos_d == '0);
    high_d     = ({1'b0, pos_d} + width_d == FW_L);
    boost_d    = (hold_cnt_d == ACC_L);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      pos_q         <= RPOS_L;
      width_q       <= INIT_L;
      hold_cnt_q    <= '0;
      last_dir_q    <= DIR_NONE;
      pend_grow_q   <= 1'b0;
      pend_shrink_q <= 1'b0;
      data_out_q    <= RMAP_L;
      low_q         <= (RPOS_L == '0);
      high_q        <= ({1'b0, RPOS_L} + INIT_L == FW_L);
      boost_q       <= 1'b0;
    end else begin
      pos_q         <= pos_d;
      width_q       <= width_d;
      hold_cnt_q    <= hold_cnt_d;
      last_dir_q    <= last_dir_d;
      pend_grow_q   <= pend_grow_d;
      pend_shrink_q <= pend_shrink_d;
      data_out_q    <= data_out_d;
      low_q         <= low_d;
      high_q        <= high_d;
      boost_q       <= boost_d;
    end
  end

  assign data_out     = data_out_q;
  assign plate_pos    = pos_q;
  assign plate_width  = width_q;
  assign at_low_edge  = low_q;
  assign at_high_edge = high_q;
  assign boost        = boost_q;

endmodule
